// File: rtl/ex_stage.sv
// ex_stage: single-cycle logic/shift/arith ALU with an optional 32-step restoring divider
// feeding HI/LO. The divider and its stall FSM exist only when EX_DIV_EN is defined.
`ifndef N_REG
`define N_REG         32
`endif
`ifndef N_REG_ADDR
`define N_REG_ADDR    5
`endif
`ifndef N_ALU_OP
`define N_ALU_OP      8
`endif
`ifndef N_ALU_SEL
`define N_ALU_SEL     3
`endif
`ifndef WRITE_DISABLE
`define WRITE_DISABLE 1'b0
`endif
`ifndef NOP_REG_ADDR
`define NOP_REG_ADDR  5'b00000
`endif
`ifndef EXE_OR_OP
`define EXE_OR_OP     8'b00100101
`define EXE_AND_OP    8'b00100100
`define EXE_XOR_OP    8'b00100110
`define EXE_NOR_OP    8'b00100111
`define EXE_SLL_OP    8'b01111100
`define EXE_SRL_OP    8'b00000010
`define EXE_SRA_OP    8'b00000011
`define EXE_SLT_OP    8'b00101010
`define EXE_SLTU_OP   8'b00101011
`define EXE_ADDU_OP   8'b00100001
`define EXE_SUBU_OP   8'b00100011
`define EXE_DIV_OP    8'b00011010
`define EXE_DIVU_OP   8'b00011011
`define EXE_RES_NOP   3'b000
`define EXE_RES_LOGIC 3'b001
`define EXE_RES_SHIFT 3'b010
`define EXE_RES_ARITH 3'b100
`endif

module ex_stage #(
   parameter int DIV_STEPS = 32
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [`N_ALU_OP-1:0]    i_ex_alu_op,
   input  logic [`N_ALU_SEL-1:0]   i_ex_alu_sel,
   input  logic [`N_REG-1:0]       i_ex_reg_0,
   input  logic [`N_REG-1:0]       i_ex_reg_1,
   input  logic                    i_ex_reg_wen,
   input  logic [`N_REG_ADDR-1:0]  i_ex_reg_waddr,
   input  logic                    i_flush,
   output logic                    o_mem_reg_wen,
   output logic [`N_REG_ADDR-1:0]  o_mem_reg_waddr,
   output logic [`N_REG-1:0]       o_mem_reg_wdata,
   output logic                    o_mem_hilo_wen,
   output logic [`N_REG-1:0]       o_mem_hi,
   output logic [`N_REG-1:0]       o_mem_lo,
   output logic                    o_stall_req
);
   logic [`N_REG-1:0] a, b, logic_res, shift_res, arith_res, wdata, hi, lo;
   logic              stall, hilo_wen;

   assign a = i_ex_reg_0;
   assign b = i_ex_reg_1;

   always_comb begin
      logic_res = '0;
      shift_res = '0;
      arith_res = '0;
      case (i_ex_alu_op)
         `EXE_OR_OP:   logic_res = a | b;
         `EXE_AND_OP:  logic_res = a & b;
         `EXE_XOR_OP:  logic_res = a ^ b;
         `EXE_NOR_OP:  logic_res = ~(a | b);
         `EXE_SLL_OP:  shift_res = b << a[4:0];
         `EXE_SRL_OP:  shift_res = b >> a[4:0];
         `EXE_SRA_OP:  shift_res = $unsigned($signed(b) >>> a[4:0]);
         `EXE_ADDU_OP: arith_res = a + b;
         `EXE_SUBU_OP: arith_res = a - b;
         `EXE_SLT_OP:  arith_res = {{(`N_REG-1){1'b0}}, $signed(a) < $signed(b)};
         `EXE_SLTU_OP: arith_res = {{(`N_REG-1){1'b0}}, a < b};
         default: ;
      endcase
   end

   always_comb begin
      wdata = '0;
      case (i_ex_alu_sel)
         `EXE_RES_LOGIC: wdata = logic_res;
         `EXE_RES_SHIFT: wdata = shift_res;
         `EXE_RES_ARITH: wdata = arith_res;
         default: ;
      endcase
   end

`ifdef EX_DIV_EN
   typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_e;
   localparam int CW = $clog2(DIV_STEPS);

   state_e            state_q, state_d;
   logic [`N_REG-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              qneg_q, qneg_d, rneg_q, rneg_d;
   logic              is_div, is_sdiv;
   logic [`N_REG:0]   trial, diff;

   assign is_sdiv = (i_ex_alu_op == `EXE_DIV_OP);
   assign is_div  = is_sdiv || (i_ex_alu_op == `EXE_DIVU_OP);
   // diff[MSB] is the borrow: set when the shifted partial remainder is below the divisor
   assign trial   = {rem_q, quo_q[`N_REG-1]};
   assign diff    = trial - {1'b0, dvs_q};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (is_div) state_d = (b == '0) ? S_BYZERO : S_ON;
         S_BYZERO: state_d = i_flush ? S_IDLE : S_END;
         S_ON:     if (i_flush) state_d = S_IDLE;
                   else if (cnt_q == CW'(DIV_STEPS - 1)) state_d = S_END;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall    = 1'b0;
      hilo_wen = 1'b0;
      case (state_q)
         S_IDLE:          stall    = is_div;
         S_BYZERO, S_ON:  stall    = !i_flush;
         S_END:           hilo_wen = !i_flush;
         default: ;
      endcase
   end

   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      case (state_q)
         S_IDLE: if (is_div) begin
            rem_d  = '0;
            cnt_d  = '0;
            quo_d  = (is_sdiv && a[`N_REG-1]) ? -a : a;
            dvs_d  = (is_sdiv && b[`N_REG-1]) ? -b : b;
            qneg_d = is_sdiv && (a[`N_REG-1] ^ b[`N_REG-1]);
            rneg_d = is_sdiv && a[`N_REG-1];
         end
         S_BYZERO: begin
            rem_d  = '0;
            quo_d  = '0;
            qneg_d = 1'b0;
            rneg_d = 1'b0;
         end
         S_ON: begin
            if (!diff[`N_REG]) begin
               rem_d = diff[`N_REG-1:0];
               quo_d = {quo_q[`N_REG-2:0], 1'b1};
            end else begin
               rem_d = trial[`N_REG-1:0];
               quo_d = {quo_q[`N_REG-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
      end
   end

   assign lo = hilo_wen ? (qneg_q ? -quo_q : quo_q) : '0;
   assign hi = hilo_wen ? (rneg_q ? -rem_q : rem_q) : '0;
`else
   logic unused_div;
   assign unused_div = i_clk ^ i_flush;
   assign stall      = 1'b0;
   assign hilo_wen   = 1'b0;
   assign hi         = '0;
   assign lo         = '0;
`endif

   // Reset gating is combinational so outputs drop the moment i_rst_n falls
   assign o_mem_reg_wen   = i_rst_n ? i_ex_reg_wen   : `WRITE_DISABLE;
   assign o_mem_reg_waddr = i_rst_n ? i_ex_reg_waddr : `NOP_REG_ADDR;
   assign o_mem_reg_wdata = i_rst_n ? wdata          : '0;
   assign o_mem_hilo_wen  = i_rst_n && hilo_wen;
   assign o_mem_hi        = i_rst_n ? hi             : '0;
   assign o_mem_lo        = i_rst_n ? lo             : '0;
   assign o_stall_req     = i_rst_n && stall;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed + randomized checks of ex_stage against an arithmetic reference model.
// Expectations follow EX_DIV_EN so the bench suits both builds.
module tb_ex_stage;
`ifdef EX_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   localparam logic [7:0] OP_NOP  = 8'h00,        OP_OR   = 8'b00100101, OP_AND  = 8'b00100100,
                          OP_XOR  = 8'b00100110,  OP_NOR  = 8'b00100111, OP_SLL  = 8'b01111100,
                          OP_SRL  = 8'b00000010,  OP_SRA  = 8'b00000011, OP_SLT  = 8'b00101010,
                          OP_SLTU = 8'b00101011,  OP_ADDU = 8'b00100001, OP_SUBU = 8'b00100011,
                          OP_DIV  = 8'b00011010,  OP_DIVU = 8'b00011011;
   localparam logic [2:0] SEL_NOP = 3'b000, SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010, SEL_ARITH = 3'b100;

   logic        clk, rst_n, wen, flush;
   logic [7:0]  op;
   logic [2:0]  sel;
   logic [31:0] r0, r1;
   logic [4:0]  waddr;
   logic        o_wen, o_hilo_wen, o_stall;
   logic [4:0]  o_waddr;
   logic [31:0] o_wdata, o_hi, o_lo;
   int          checks = 0, errors = 0;

   ex_stage dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_ex_alu_op(op), .i_ex_alu_sel(sel),
      .i_ex_reg_0(r0), .i_ex_reg_1(r1), .i_ex_reg_wen(wen), .i_ex_reg_waddr(waddr),
      .i_flush(flush), .o_mem_reg_wen(o_wen), .o_mem_reg_waddr(o_waddr),
      .o_mem_reg_wdata(o_wdata), .o_mem_hilo_wen(o_hilo_wen), .o_mem_hi(o_hi),
      .o_mem_lo(o_lo), .o_stall_req(o_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] o, input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                        input logic w, input logic [4:0] wa);
      op = o; sel = s; r0 = a; r1 = b; wen = w; waddr = wa;
   endtask

   function automatic logic [31:0] ref_alu(input logic [7:0] o, input logic [2:0] s,
                                           input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic [2:0]  cls;
      int          sh;
      sh = int'(a[4:0]);
      r = 32'h0; cls = SEL_NOP;
      case (o)
         OP_OR:   begin r = a | b;    cls = SEL_LOGIC; end
         OP_AND:  begin r = a & b;    cls = SEL_LOGIC; end
         OP_XOR:  begin r = a ^ b;    cls = SEL_LOGIC; end
         OP_NOR:  begin r = ~(a | b); cls = SEL_LOGIC; end
         OP_SLL:  begin r = b << sh;  cls = SEL_SHIFT; end
         OP_SRL:  begin r = b >> sh;  cls = SEL_SHIFT; end
         OP_SRA:  begin r = (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0); cls = SEL_SHIFT; end
         OP_ADDU: begin r = a + b;    cls = SEL_ARITH; end
         OP_SUBU: begin r = a - b;    cls = SEL_ARITH; end
         OP_SLT:  begin r = (int'(a) < int'(b)) ? 32'd1 : 32'd0; cls = SEL_ARITH; end
         OP_SLTU: begin r = (a < b) ? 32'd1 : 32'd0; cls = SEL_ARITH; end
         default: ;
      endcase
      return (s == cls && s != SEL_NOP) ? r : 32'h0;
   endfunction

   task automatic ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r);
      int sa, sb;
      sa = int'(a); sb = int'(b);
      if (b == 32'h0) begin q = 32'h0; r = 32'h0; end
      else if (!sgn) begin q = a / b; r = a % b; end
      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = 32'h8000_0000; r = 32'h0; end
      else begin q = 32'(sa / sb); r = 32'(sa % sb); end
   endtask

   task automatic alu_step(input string tag, input logic [7:0] o, input logic [2:0] s, input logic [31:0] a,
                           input logic [31:0] b, input logic w, input logic [4:0] wa, input logic [31:0] exp);
      @(posedge clk); #1;
      drive(o, s, a, b, w, wa);
      @(negedge clk);
      chk({tag, "_wdata"}, o_wdata, exp);
      chk({tag, "_wen"}, o_wen, w);
      chk({tag, "_waddr"}, o_waddr, wa);
      chk({tag, "_stall"}, o_stall, 0);
      chk({tag, "_hilo_wen"}, o_hilo_wen, 0);
   endtask

   task automatic do_div(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      int n, pulses, exp_n;
      ref_div(sgn, a, b, q, r);
      exp_n = !DIV_EN ? 0 : ((b == 32'h0) ? 2 : 33);
      @(posedge clk); #1;
      drive(sgn ? OP_DIV : OP_DIVU, SEL_NOP, a, b, 1'b0, 5'd0);
      n = 0; pulses = 0;
      @(negedge clk);
      while (o_stall && n < 100) begin
         pulses += int'(o_hilo_wen);
         n++;
         @(negedge clk);
      end
      chk({tag, "_stall_cycles"}, n, exp_n);
      chk({tag, "_hilo_during_stall"}, pulses, 0);
      chk({tag, "_hilo_wen"}, o_hilo_wen, DIV_EN);
      chk({tag, "_lo"}, o_lo, DIV_EN ? q : 32'h0);
      chk({tag, "_hi"}, o_hi, DIV_EN ? r : 32'h0);
      @(posedge clk); #1;
      drive(OP_NOP, SEL_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
      @(negedge clk);
      chk({tag, "_after_hilo_wen"}, o_hilo_wen, 0);
      chk({tag, "_after_stall"}, o_stall, 0);
   endtask

   task automatic idle_watch(input string tag, input int cycles);
      int st, hw;
      st = 0; hw = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         st += int'(o_stall);
         hw += int'(o_hilo_wen);
      end
      chk({tag, "_stall_count"}, st, 0);
      chk({tag, "_hilo_count"}, hw, 0);
   endtask

   logic [7:0]  ops  [11] = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                              OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU};
   logic [2:0]  sels [11] = '{SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_SHIFT, SEL_SHIFT,
                              SEL_SHIFT, SEL_ARITH, SEL_ARITH, SEL_ARITH, SEL_ARITH};

   initial begin
      logic [7:0]  ro;
      logic [2:0]  rs;
      logic [31:0] ra, rb;
      logic        rw;
      logic [4:0]  rwa;
      int          k;

      rst_n = 1'b0; flush = 1'b0;
      drive(OP_OR, SEL_LOGIC, 32'h0000_F0F0, 32'h0000_0F0F, 1'b1, 5'd5);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wen", o_wen, 0);
      chk("rst_waddr", o_waddr, 0);
      chk("rst_wdata", o_wdata, 0);
      chk("rst_stall", o_stall, 0);
      chk("rst_hilo", {o_hilo_wen, o_hi[30:0]} | o_lo, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("or_wdata", o_wdata, 32'h0000_FFFF);
      chk("or_wen", o_wen, 1);
      chk("or_waddr", o_waddr, 5);
      chk("or_stall", o_stall, 0);

      alu_step("sra", OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0000, 1'b1, 5'd9, 32'hF800_0000);
      alu_step("sltu", OP_SLTU, SEL_ARITH, 32'd1, 32'hFFFF_FFFF, 1'b1, 5'd3, 32'd1);
      alu_step("slt", OP_SLT, SEL_ARITH, 32'd1, 32'hFFFF_FFFF, 1'b1, 5'd3, 32'd0);
      alu_step("nopsel", OP_ADDU, SEL_NOP, 32'd7, 32'd8, 1'b0, 5'd31, 32'd0);
      alu_step("subu_wrap", OP_SUBU, SEL_ARITH, 32'd0, 32'd1, 1'b1, 5'd1, 32'hFFFF_FFFF);

      for (int i = 0; i < 40; i++) begin
         k   = $urandom_range(10, 0);
         ro  = ops[k];
         rs  = ($urandom_range(7, 0) == 0) ? SEL_NOP : sels[k];
         ra  = $urandom;
         rb  = $urandom;
         rw  = 1'($urandom_range(1, 0));
         rwa = 5'($urandom_range(31, 0));
         alu_step("rand_alu", ro, rs, ra, rb, rw, rwa, ref_alu(ro, rs, ra, rb));
      end

      do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
      do_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h10);
      do_div("divu_by0", 1'b0, 32'd5, 32'd0);
      do_div("div_by0", 1'b1, 32'h8000_0001, 32'd0);
      do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      do_div("div_negb", 1'b1, 32'd100, 32'hFFFF_FFF9);
      for (int i = 0; i < 4; i++) begin
         ra = $urandom;
         rb = (i[0]) ? 32'($urandom_range(1000, 1)) : $urandom;
         do_div("rand_div", 1'(i >> 1), ra, rb);
      end

      // Flush lands on the 10th stall cycle of a divide
      @(posedge clk); #1;
      drive(OP_DIVU, SEL_NOP, 32'h1234_5678, 32'd3, 1'b0, 5'd0);
      for (int c = 1; c < 10; c++) begin
         @(negedge clk);
         chk("flush_pre_stall", o_stall, DIV_EN);
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(negedge clk);
      chk("flush_stall", o_stall, 0);
      chk("flush_hilo", o_hilo_wen, 0);
      @(posedge clk); #1;
      flush = 1'b0;
      drive(OP_NOP, SEL_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
      idle_watch("flush_after", 40);
      do_div("divu_9_3", 1'b0, 32'd9, 32'd3);

      // Async reset on the 5th cycle of a divide
      @(posedge clk); #1;
      drive(OP_DIV, SEL_NOP, 32'd1000, 32'd7, 1'b1, 5'd7);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_stall", o_stall, 0);
      chk("mid_rst_wen", o_wen, 0);
      chk("mid_rst_waddr", o_waddr, 0);
      chk("mid_rst_hilo", o_hilo_wen, 0);
      chk("mid_rst_hi_lo", o_hi | o_lo | o_wdata, 0);
      @(posedge clk); #1;
      drive(OP_NOP, SEL_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
      rst_n = 1'b1;
      idle_watch("rst_after", 40);
      do_div("post_rst_div", 1'b1, 32'd1000, 32'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
